decode_stage: RTL

Instruction decode stage of the RV32I pipeline: accepts fetched instructions over a valid/ready handshake, drives the register-file read selects combinationally, and captures operands, immediate and control fields into the ID/EX pipeline register consumed by execute. It detects load-use hazards and inserts bubbles. Write-back-to-decode hazards are already resolved by the register file's negedge write, so this stage does no write-back forwarding.

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/imm_gen.sv | 20 ++
 rtl/decode_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I widths, opcode constants and immediate-format classification
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // FMT_X marks an unrecognised opcode (including InstrDat[1:0] != 2'b11)
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} imm_fmt_e;

    function automatic imm_fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_REG:                   return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: classifies the instruction format and builds its sign-extended immediate
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    always_comb begin
        fmt = fmt_of(instr[6:0]);
        imm = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
              fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              fmt == FMT_U ? {instr[31:12], 12'b0} :
              fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              '0;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with load-use bubble insertion and the ID/EX pipeline register
module decode_stage
    import rv32_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            InstrValid,
    input  logic [31:0]     InstrDat,
    input  logic [XLEN-1:0] InstrPC,
    output logic            InstrReady,
    output logic [REGW-1:0] RS1Sel,
    output logic [REGW-1:0] RS2Sel,
    input  logic [XLEN-1:0] RS1Dat,
    input  logic [XLEN-1:0] RS2Dat,
    input  logic            Flush,
    input  logic            ExReady,
    output logic            ExValid,
    output logic [XLEN-1:0] ExPC,
    output logic [XLEN-1:0] ExRS1,
    output logic [XLEN-1:0] ExRS2,
    output logic [XLEN-1:0] ExImm,
    output logic [REGW-1:0] ExRD,
    output logic [6:0]      ExOpcode,
    output logic [2:0]      ExFunct3,
    output logic            ExFunct7b5,
    output logic            ExRegWen,
    output logic            ExMemRead,
    output logic            ExMemWrite,
    output logic            ExIllegal
);

    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [REGW-1:0] rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            has_rd;
    logic            stall;
    logic            advance;
    logic            accept;

    imm_gen u_imm_gen (
        .instr (InstrDat),
        .imm   (imm),
        .fmt   (fmt)
    );

    assign RS1Sel = InstrDat[19:15];
    assign RS2Sel = InstrDat[24:20];

    always_comb begin
        uses_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
        has_rd   = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
        rd       = has_rd ? InstrDat[11:7] : '0;
    end

    // A load still in ID/EX cannot supply its result to the instruction behind it
    assign stall = InstrValid & ExValid & ExMemRead & (|ExRD) &
                   ((uses_rs1 & (ExRD == RS1Sel)) | (uses_rs2 & (ExRD == RS2Sel)));

    assign advance    = ExReady | ~ExValid;
    assign InstrReady = advance & ~stall & ~Flush;
    assign accept     = InstrValid & InstrReady;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ExValid    <= 1'b0;
            ExPC       <= '0;
            ExRS1      <= '0;
            ExRS2      <= '0;
            ExImm      <= '0;
            ExRD       <= '0;
            ExOpcode   <= '0;
            ExFunct3   <= '0;
            ExFunct7b5 <= 1'b0;
            ExRegWen   <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExIllegal  <= 1'b0;
        end else begin
            ExValid <= Flush ? 1'b0 : advance ? InstrValid & ~stall : ExValid;
            if (accept) begin
                ExPC       <= InstrPC;
                ExRS1      <= RS1Dat;
                ExRS2      <= RS2Dat;
                ExImm      <= imm;
                ExRD       <= rd;
                ExOpcode   <= InstrDat[6:0];
                ExFunct3   <= InstrDat[14:12];
                ExFunct7b5 <= InstrDat[30];
                ExRegWen   <= has_rd & (|rd);
                ExMemRead  <= InstrDat[6:0] == OP_LOAD;
                ExMemWrite <= InstrDat[6:0] == OP_STORE;
                ExIllegal  <= fmt == FMT_X;
            end
        end
    end

endmodule
